// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state type, default sizing and round-robin search for the UART TX arbiter
package uart_arb_pkg;
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} arb_state_e;
  localparam int UART_ARB_N_REQ = 2;
  localparam int UART_ARB_MAX_BURST = 64;
  // lowest offset from ptr (with wrap) wins, so scan offsets high-to-low and keep the last hit
  function automatic int rr_pick(input logic [7:0] valid, input int ptr, input int n);
    int pick;
    int idx;
    pick = 0;
    for (int k = n - 1; k >= 0; k--) begin
      idx = (ptr + k) % n;
      if (valid[idx]) pick = idx;
    end
    return pick;
  endfunction
endpackage

// File: rtl/cdc_sync2.sv
// cdc_sync2: two-flop synchronizer for asynchronous pad inputs with selectable reset value
module cdc_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {q, meta} <= {RST_VAL, RST_VAL};
    else {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin message arbiter feeding one UART transmitter with CTS flow control
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = UART_ARB_N_REQ,
  parameter int MAX_BURST = UART_ARB_MAX_BURST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     cts_n,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);
  localparam int GW = $clog2(N_REQ);
  arb_state_e state;
  logic [GW-1:0] rr_ptr;
  logic [8:0] cnt;
  logic cts_s;
  logic acc;
  cdc_sync2 #(.RST_VAL(1'b1)) u_cts (.clk(clk), .rst_n(rst_n), .d(cts_n), .q(cts_s));
  // the output register may reload in the same cycle it is drained
  assign acc = state == XFER && req_valid[grant_id] && !cts_s && (!tx_valid || tx_ready);
  assign req_ready = {{(N_REQ-1){1'b0}}, acc} << grant_id;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      cnt <= '0;
      grant_id <= '0;
      tx_valid <= 1'b0;
      tx_data <= '0;
    end else begin
      if (acc) begin
        tx_valid <= 1'b1;
        tx_data <= req_data[8*grant_id +: 8];
      end else if (tx_ready) tx_valid <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          grant_id <= GW'(rr_pick(8'(req_valid), int'(rr_ptr), N_REQ));
          cnt <= '0;
          state <= XFER;
        end
        XFER: if (acc) begin
          cnt <= cnt + 9'd1;
          if (req_last[grant_id] || cnt == 9'(MAX_BURST - 1)) state <= DRAIN;
        end
        DRAIN: if (!tx_valid || tx_ready) begin
          state <= IDLE;
          rr_ptr <= grant_id == GW'(N_REQ - 1) ? '0 : grant_id + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares the single UART transmit path of the FPGA top level between several byte-stream requesters (console, trap/status reporter, debug dump). A granted requester holds the UART for a whole message, which ends on its `last` byte or after `MAX_BURST` bytes. The block honours the board's RTS/CTS flow control on the CTS pin and presents bytes to the UART transmitter through a one-entry output register with a valid/ready handshake.

## Interface
- `N_REQ`, 2: number of requesters, 2..8.
- `MAX_BURST`, 64: maximum bytes per grant, 1..256.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input N_REQ: per-requester byte valid.
- `req_data` input 8*N_REQ: per-requester byte; requester i uses bits [8i+7:8i].
- `req_last` input N_REQ: marks the final byte of a message.
- `req_ready` output N_REQ: byte accepted in this cycle when valid and ready are both high; one-hot or zero.
- `cts_n` input 1: raw UART CTS pin, active-low, asynchronous to `clk`.
- `tx_valid` output 1: byte presented to the UART transmitter.
- `tx_data` output 8: byte for the UART transmitter.
- `tx_ready` input 1: UART transmitter accepts `tx_data`.
- `grant_id` output $clog2(N_REQ): current or most recent grantee.
- `busy` output 1: high in the XFER and DRAIN states.

## Operation
- `cts_n` passes through a 2-flop synchronizer that resets to 1. `cts_ok` = synchronized `cts_n` == 0.
- Output register: `obuf_full` drives `tx_valid`. `obuf_full` clears on `tx_ready` and sets on acceptance of a requester byte. Acceptance is allowed when `!obuf_full || tx_ready`, which gives back-to-back throughput.
- Once `tx_valid` is high, `tx_valid` and `tx_data` hold unchanged until `tx_ready`, regardless of CTS.
- The FSM states are IDLE, XFER and DRAIN.
- IDLE:
  - If any `req_valid` is high, grant the first valid index at or after `rr_ptr`, searching with wrap-around.
  - Load `grant_id`, clear `cnt`, and go to XFER.
  - No byte is accepted in this cycle.
- XFER:
  - `req_ready[grant_id]` = `req_valid[grant_id]` && `cts_ok` && (`!obuf_full` || `tx_ready`).
  - Each acceptance increments `cnt`. `cnt` is 9 bits wide and cannot wrap, because MAX_BURST ≤ 256.
  - Go to DRAIN when the accepted byte has `req_last` high, or when `cnt` == MAX_BURST-1 at acceptance.
  - The grantee dropping `req_valid` does not end the grant. The FSM waits in XFER.
- DRAIN:
  - No `req_ready` is asserted.
  - When `obuf_full` == 0, or is clearing in this cycle, go to IDLE.
  - `rr_ptr` = `grant_id`+1, wrapping modulo N_REQ.
- `req_ready` to non-granted requesters is always 0.
- A requester whose `req_valid` and `req_last` are high when it is granted gets a 1-byte grant.

## Timing
- Reset values: `req_ready`=0, `tx_valid`=0, `tx_data`=0, `grant_id`=0, `busy`=0. Internally: state=IDLE, `rr_ptr`=0, `cnt`=0, CTS sync flops=1.
- Reset is asynchronous. Asserting `rst_n` low drops `tx_valid` and all outputs immediately, even mid-message or with a byte pending.
- The first `req_ready` follows 1 cycle after the grant cycle. After reset release, CTS adds a further 2 cycles of synchronizer latency.
- Acceptance to `tx_valid`: 1 cycle.
- Sustained rate: 1 byte/cycle while `tx_ready`=1 and `cts_ok`=1.
- Changes on `cts_n` take effect on `req_ready` 2 cycles later. An in-flight `obuf` byte is still delivered.
- Inter-message gap: the DRAIN exit cycle, then 1 IDLE grant cycle.
- Simultaneous `tx_ready` and acceptance in the same cycle: `obuf` reloads, and `tx_valid` stays 1.

## Structure
- Shared package `uart_arb_pkg`:
  - state enum `arb_state_e` {IDLE, XFER, DRAIN};
  - default constants `UART_ARB_N_REQ`=2 and `UART_ARB_MAX_BURST`=64.
- Sub-module `cdc_sync2`: 2-flop synchronizer with parameterized reset value, used for `cts_n`. It is reused by other pad inputs.
- The round-robin priority search is a combinational function in the package. It takes the valid vector and the pointer and returns the index.

## Test plan
- Single requester:
  - Stimulus: requester 0 sends "AB" with `last` on 'B', `tx_ready`=1, `cts_n`=0.
  - Required: `tx_data` = 0x41 then 0x42 on consecutive cycles, then `busy` falls after DRAIN and `grant_id` = 0.
- Round-robin:
  - Stimulus: both requesters hold valid, each message 1 byte with `last`.
  - Required: grant sequence 0,1,0,1. No interleaving of bytes within a message.
- Burst cap:
  - Stimulus: MAX_BURST=4, requester 1 streams 10 bytes with no `last`, requester 0 valid.
  - Required: after 4 bytes from requester 1, requester 0 is granted.
- CTS stall:
  - Stimulus: raise `cts_n` to 1 mid-message while a byte is pending in `obuf`.
  - Required: the pending byte completes, and `req_ready` stays 0 from 2 cycles after the raise until 2 cycles after `cts_n` returns to 0. No byte is lost or duplicated.
- Backpressure:
  - Stimulus: `tx_ready`=0 for 5 cycles with `tx_valid`=1 and `tx_data`=0x5A.
  - Required: `tx_data` is held at 0x5A, and `req_ready`=0 throughout.
- Reset mid-message:
  - Stimulus: assert `rst_n` low during XFER.
  - Required: `tx_valid`, `req_ready` and `busy` go to 0 without waiting for `clk`, and after release the first grant is to requester 0.
